ps2_mouse_init_ctrl: RTL and testbench

//  Host-side PS/2 mouse configuration sequencer. Drives the open-drain PS/2 clk/data lines to reset the mouse,

---
 rtl/ps2_mouse_init_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_ps2_mouse_init_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_init_ctrl.sv
// Host-side PS/2 mouse init sequencer: reset, sample rate, resolution, stream enable, reply checking.
// Define PS2_WHEEL_DETECT_EN to insert the wheel-mouse probe (F3 C8/64/50, F2) and capture mouse_id.
module ps2_mouse_init_ctrl #(
   parameter logic [7:0] SAMPLE_RATE   = 8'd100,
   parameter logic [7:0] RESOLUTION    = 8'd2,
   parameter int         INHIBIT_TICKS = 600,
   parameter int         TMO_TICKS     = 3000000,
   parameter int         MAX_RETRY     = 3
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ce_6mp,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic       start,
   output logic       busy,
   output logic       ready,
   output logic       error,
   output logic [7:0] mouse_id
);

   localparam int TMAX = (TMO_TICKS > INHIBIT_TICKS) ? TMO_TICKS : INHIBIT_TICKS;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int RW   = $clog2(MAX_RETRY + 1);
`ifdef PS2_WHEEL_DETECT_EN
   localparam logic [3:0] LAST_STEP = 4'd12;
   localparam logic [3:0] ID_STEP   = 4'd7;
`else
   localparam logic [3:0] LAST_STEP = 4'd5;
`endif

   typedef enum logic [2:0] {S_SEND, S_INHIBIT, S_TX, S_RX, S_READY, S_ERROR} state_t;

   state_t          state, state_n;
   logic [3:0]      step, step_n, nbit, nbit_n;
   logic [1:0]      ridx, ridx_n, fe_cnt, fe_n;
   logic [9:0]      rx_sh, rx_sh_n;
   logic [RW-1:0]   retry, retry_n;
   logic            bad_seen, bad_n;
   logic [7:0]      id_n, tx_b, rx_byte;
   logic [TW-1:0]   tick;
   logic            clk_s1, clk_s2, clk_prev, data_s1, data_s;
   logic            clk_fall, clk_edge, tmo, rx_ok, fail, adv, tx_bit_oe;

   function automatic logic [7:0] cmd_byte(input logic [3:0] s);
`ifdef PS2_WHEEL_DETECT_EN
      case (s)
         4'd0:    return 8'hFF;
         4'd1:    return 8'hF3;
         4'd2:    return 8'hC8;
         4'd3:    return 8'hF3;
         4'd4:    return 8'h64;
         4'd5:    return 8'hF3;
         4'd6:    return 8'h50;
         4'd7:    return 8'hF2;
         4'd8:    return 8'hF3;
         4'd9:    return SAMPLE_RATE;
         4'd10:   return 8'hE8;
         4'd11:   return RESOLUTION;
         default: return 8'hF4;
      endcase
`else
      case (s)
         4'd0:    return 8'hFF;
         4'd1:    return 8'hF3;
         4'd2:    return SAMPLE_RATE;
         4'd3:    return 8'hE8;
         4'd4:    return RESOLUTION;
         default: return 8'hF4;
      endcase
`endif
   endfunction

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         {clk_s1, clk_s2, clk_prev} <= 3'b111;
         {data_s1, data_s}          <= 2'b11;
      end else begin
         {clk_prev, clk_s2, clk_s1} <= {clk_s2, clk_s1, ps2_clk_in};
         {data_s, data_s1}          <= {data_s1, ps2_data_in};
      end
   end

   assign clk_fall = clk_prev & ~clk_s2;
   assign clk_edge = clk_prev ^ clk_s2;
   assign tmo      = ce_6mp && (tick == TW'(TMO_TICKS - 1));
   assign tx_b     = cmd_byte(step);
   assign rx_byte  = rx_sh[8:1];
   assign rx_ok    = ~rx_sh[0] & data_s & (rx_sh[9] == ~^rx_sh[8:1]);

   // Host frame: start (pulled), data LSB first, odd parity, stop (released).
   always_comb begin
      tx_bit_oe = 1'b0;
      if (nbit == 4'd0)       tx_bit_oe = 1'b1;
      else if (nbit <= 4'd8)  tx_bit_oe = ~tx_b[3'(nbit - 4'd1)];
      else if (nbit == 4'd9)  tx_bit_oe = ^tx_b;
   end

   always_comb begin
      state_n = state;
      step_n  = step;
      nbit_n  = nbit;
      ridx_n  = ridx;
      rx_sh_n = rx_sh;
      retry_n = retry;
      fe_n    = fe_cnt;
      bad_n   = bad_seen;
      id_n    = mouse_id;
      fail    = 1'b0;
      adv     = 1'b0;
      case (state)
         S_SEND: begin
            state_n = S_INHIBIT;
            nbit_n  = '0;
            ridx_n  = '0;
         end
         S_INHIBIT: if (ce_6mp && tick == TW'(INHIBIT_TICKS - 1)) state_n = S_TX;
         S_TX: begin
            if (clk_fall) begin
               if (nbit == 4'd10) begin
                  if (data_s) fail = 1'b1;
                  else begin
                     state_n = S_RX;
                     nbit_n  = '0;
                  end
               end else nbit_n = nbit + 4'd1;
            end else if (tmo) fail = 1'b1;
         end
         S_RX: begin
            if (clk_fall) begin
               nbit_n  = nbit + 4'd1;
               rx_sh_n = {data_s, rx_sh[9:1]};
               if (nbit == 4'd10) begin
                  nbit_n = '0;
                  // A corrupt frame asks for one resend, like an FE from the device.
                  if (!rx_ok) begin
                     if (bad_seen) fail = 1'b1;
                     else begin
                        bad_n   = 1'b1;
                        state_n = S_SEND;
                     end
                  end else if (rx_byte == 8'hFE) begin
                     if (fe_cnt == 2'd2) fail = 1'b1;
                     else begin
                        fe_n    = fe_cnt + 2'd1;
                        state_n = S_SEND;
                     end
                  end else if (step == 4'd0) begin
                     case (ridx)
                        2'd0: if (rx_byte == 8'hFA) ridx_n = 2'd1;
                              else if (rx_byte == 8'hAA) ridx_n = 2'd2;
                              else fail = 1'b1;
                        2'd1: if (rx_byte == 8'hAA) ridx_n = 2'd2; else fail = 1'b1;
                        default: if (rx_byte == 8'h00) adv = 1'b1; else fail = 1'b1;
                     endcase
`ifdef PS2_WHEEL_DETECT_EN
                  end else if (step == ID_STEP && ridx == 2'd1) begin
                     id_n = rx_byte;
                     adv  = 1'b1;
                  end else if (step == ID_STEP) begin
                     if (rx_byte == 8'hFA) ridx_n = 2'd1; else fail = 1'b1;
`endif
                  end else if (rx_byte == 8'hFA) adv = 1'b1;
                  else fail = 1'b1;
               end
            end else if (tmo) fail = 1'b1;
         end
         default: ;
      endcase
      if (adv) begin
         fe_n    = '0;
         bad_n   = 1'b0;
         step_n  = step + 4'd1;
         state_n = (step == LAST_STEP) ? S_READY : S_SEND;
      end
      if (fail) begin
         retry_n = retry + 1'b1;
         fe_n    = '0;
         bad_n   = 1'b0;
         step_n  = '0;
         state_n = (retry == RW'(MAX_RETRY - 1)) ? S_ERROR : S_SEND;
      end
      if (start) begin
         state_n = S_SEND;
         step_n  = '0;
         nbit_n  = '0;
         ridx_n  = '0;
         retry_n = '0;
         fe_n    = '0;
         bad_n   = 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state    <= S_SEND;
         step     <= '0;
         nbit     <= '0;
         ridx     <= '0;
         rx_sh    <= '0;
         retry    <= '0;
         fe_cnt   <= '0;
         bad_seen <= 1'b0;
         mouse_id <= 8'h00;
         tick     <= '0;
      end else begin
         state    <= state_n;
         step     <= step_n;
         nbit     <= nbit_n;
         ridx     <= ridx_n;
         rx_sh    <= rx_sh_n;
         retry    <= retry_n;
         fe_cnt   <= fe_n;
         bad_seen <= bad_n;
         mouse_id <= id_n;
         if (state_n != state || clk_edge) tick <= '0;
         else if (ce_6mp && state inside {S_INHIBIT, S_TX, S_RX}) tick <= tick + 1'b1;
      end
   end

   assign ps2_clk_oe  = (state == S_INHIBIT);
   assign ps2_data_oe = (state == S_TX) && tx_bit_oe;
   assign busy        = !(state inside {S_READY, S_ERROR});
   assign ready       = (state == S_READY);
   assign error       = (state == S_ERROR);

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Bench for ps2_mouse_init_ctrl: acts as the PS/2 mouse, a table of reply scenarios plus timeout/reset corner cases.
module tb_ps2_mouse_init_ctrl;
   localparam int INH  = 20;
   localparam int TMO  = 2000;
   localparam int HALF = 4;
`ifdef PS2_WHEEL_DETECT_EN
   localparam logic [7:0] EXP_ID = 8'h03;
`else
   localparam logic [7:0] EXP_ID = 8'h00;
`endif

   logic clk_sys = 1'b0, reset = 1'b1, ce_6mp = 1'b1, start = 1'b0;
   logic dev_clk = 1'b1, dev_data = 1'b1;
   logic ps2_clk_oe, ps2_data_oe, busy, ready, error;
   logic [7:0] mouse_id;
   wire  clk_line  = dev_clk & ~ps2_clk_oe;
   wire  data_line = dev_data & ~ps2_data_oe;

   int n_vec = 0, n_bad = 0;

   typedef struct { int mode; int n; logic [127:0] tx; } vec_t;
   vec_t vecs[5];

   ps2_mouse_init_ctrl #(.SAMPLE_RATE(8'd100), .RESOLUTION(8'd2), .INHIBIT_TICKS(INH),
                         .TMO_TICKS(TMO), .MAX_RETRY(3)) dut (
      .clk_sys(clk_sys), .reset(reset), .ce_6mp(ce_6mp),
      .ps2_clk_in(clk_line), .ps2_data_in(data_line),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .start(start), .busy(busy), .ready(ready), .error(error), .mouse_id(mouse_id));

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] lal(input logic [127:0] x, input int n);
      return x << (8 * (16 - n));
   endfunction

   task automatic pulse_start();
      @(negedge clk_sys) start = 1'b1;
      @(negedge clk_sys) start = 1'b0;
   endtask

   // Device side of a host-to-device byte; abort_n > 0 stops after that many clocks.
   task automatic dev_recv(output logic [7:0] b, output bit got, input int abort_n);
      logic [9:0] s;
      int t;
      got = 1'b0;
      b   = 8'h00;
      s   = '0;
      t   = 0;
      while (!ps2_clk_oe && t < 3000) begin @(negedge clk_sys); t++; end
      if (!ps2_clk_oe) return;
      t = 0;
      while (!(!ps2_clk_oe && ps2_data_oe) && t < 500) begin @(negedge clk_sys); t++; end
      if (ps2_clk_oe || !ps2_data_oe) return;
      repeat (HALF) @(negedge clk_sys);
      for (int i = 0; i < 10; i++) begin
         if (abort_n != 0 && i == abort_n) begin got = 1'b1; return; end
         dev_clk = 1'b0; repeat (HALF) @(negedge clk_sys);
         dev_clk = 1'b1; repeat (HALF) @(negedge clk_sys);
         s[i] = data_line;
      end
      b = s[7:0];
      check($sformatf("tx_parity_%0h", b), 32'(s[8]), 32'(~^s[7:0]));
      check($sformatf("tx_stop_%0h", b), 32'(s[9]), 32'd1);
      dev_data = 1'b0; repeat (HALF) @(negedge clk_sys);
      dev_clk  = 1'b0; repeat (HALF) @(negedge clk_sys);
      dev_clk  = 1'b1; dev_data = 1'b1;
      repeat (2 * HALF) @(negedge clk_sys);
      got = 1'b1;
   endtask

   task automatic dev_send(input logic [7:0] b, input bit badpar);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ badpar, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         dev_data = f[i];   repeat (HALF) @(negedge clk_sys);
         dev_clk  = 1'b0;   repeat (HALF) @(negedge clk_sys);
         dev_clk  = 1'b1;
      end
      dev_data = 1'b1;
      repeat (2 * HALF) @(negedge clk_sys);
   endtask

   // Plays one table scenario: checks every byte the host sends, answers per mode.
   task automatic run_vec(input int vi, input int abort_idx);
      logic [7:0] b;
      bit got, once;
      once = 1'b0;
      for (int k = 0; k < vecs[vi].n; k++) begin
         dev_recv(b, got, (k == abort_idx) ? 4 : 0);
         check($sformatf("v%0d_req%0d", vi, k), 32'(got), 32'd1);
         if (!got) return;
         if (k == abort_idx) begin
            // Bit 3 of F4 is 0, so data is pulled low at this point.
            check("mid_tx_data_oe", 32'(ps2_data_oe), 32'd1);
            reset = 1'b1;
            @(posedge clk_sys); #1;
            check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            check("rst_mid_busy", {30'd0, busy, ready}, 32'd2);
            @(negedge clk_sys) reset = 1'b0;
            return;
         end
         check($sformatf("v%0d_tx%0d", vi, k), 32'(b), 32'(vecs[vi].tx[127 - 8*k -: 8]));
         case (b)
            8'hFF: if (vecs[vi].mode == 3 && !once) begin
                      once = 1'b1; dev_send(8'hAA, 1'b0); dev_send(8'h00, 1'b0);
                   end else begin
                      dev_send(8'hFA, 1'b0); dev_send(8'hAA, 1'b0); dev_send(8'h00, 1'b0);
                   end
            8'hF2: begin dev_send(8'hFA, 1'b0); dev_send(8'h03, 1'b0); end
            8'hF3: if (vecs[vi].mode == 1 && !once) begin once = 1'b1; dev_send(8'hFE, 1'b0); end
                   else if (vecs[vi].mode == 4 && !once) begin once = 1'b1; dev_send(8'hFC, 1'b0); end
                   else dev_send(8'hFA, 1'b0);
            8'hE8: if (vecs[vi].mode == 2 && !once) begin once = 1'b1; dev_send(8'hFA, 1'b1); end
                   else dev_send(8'hFA, 1'b0);
            default: dev_send(8'hFA, 1'b0);
         endcase
      end
   endtask

   task automatic check_done(input string nm);
      repeat (30) @(negedge clk_sys);
      check({nm, "_ready"}, 32'(ready), 32'd1);
      check({nm, "_busy"},  32'(busy),  32'd0);
      check({nm, "_error"}, 32'(error), 32'd0);
      check({nm, "_oe"},    {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      check({nm, "_id"},    32'(mouse_id), 32'(EXP_ID));
   endtask

   initial begin
      int rises, t;
      logic prev_oe;
`ifdef PS2_WHEEL_DETECT_EN
      vecs[0] = '{mode: 0, n: 13, tx: lal(128'hFF_F3_C8_F3_64_F3_50_F2_F3_64_E8_02_F4, 13)};
      vecs[1] = '{mode: 1, n: 14, tx: lal(128'hFF_F3_F3_C8_F3_64_F3_50_F2_F3_64_E8_02_F4, 14)};
      vecs[2] = '{mode: 2, n: 14, tx: lal(128'hFF_F3_C8_F3_64_F3_50_F2_F3_64_E8_E8_02_F4, 14)};
      vecs[3] = '{mode: 3, n: 13, tx: lal(128'hFF_F3_C8_F3_64_F3_50_F2_F3_64_E8_02_F4, 13)};
      vecs[4] = '{mode: 4, n: 15, tx: lal(128'hFF_F3_FF_F3_C8_F3_64_F3_50_F2_F3_64_E8_02_F4, 15)};
`else
      vecs[0] = '{mode: 0, n: 6, tx: lal(128'hFF_F3_64_E8_02_F4, 6)};
      vecs[1] = '{mode: 1, n: 7, tx: lal(128'hFF_F3_F3_64_E8_02_F4, 7)};
      vecs[2] = '{mode: 2, n: 7, tx: lal(128'hFF_F3_64_E8_E8_02_F4, 7)};
      vecs[3] = '{mode: 3, n: 6, tx: lal(128'hFF_F3_64_E8_02_F4, 6)};
      vecs[4] = '{mode: 4, n: 8, tx: lal(128'hFF_F3_FF_F3_64_E8_02_F4, 8)};
`endif
      repeat (3) @(negedge clk_sys);
      check("rst_clk_oe",  32'(ps2_clk_oe),  32'd0);
      check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      check("rst_busy",    32'(busy),        32'd1);
      check("rst_ready",   32'(ready),       32'd0);
      check("rst_error",   32'(error),       32'd0);
      check("rst_id",      32'(mouse_id),    32'd0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         if (i > 0) pulse_start();
         run_vec(i, -1);
         check_done($sformatf("v%0d", i));
      end

      // Silent device: three inhibits, then sticky error with lines released.
      pulse_start();
      rises = 0; t = 0; prev_oe = ps2_clk_oe;
      while (!error && t < 10000) begin
         @(negedge clk_sys); t++;
         if (ps2_clk_oe && !prev_oe) rises++;
         prev_oe = ps2_clk_oe;
      end
      check("silent_error", 32'(error), 32'd1);
      check("silent_tries", 32'(rises), 32'd3);
      check("silent_busy",  {30'd0, busy, ready}, 32'd0);
      check("silent_oe",    {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      repeat (50) @(negedge clk_sys);
      check("error_sticky", 32'(error), 32'd1);
      pulse_start();
      check("start_clr_error", 32'(error), 32'd0);
      check("start_busy",      32'(busy),  32'd1);
      run_vec(0, -1);
      check_done("after_error");

      // Reset during the F4 transmit, then the full sequence again from FF.
      pulse_start();
      run_vec(0, vecs[0].n - 1);
      run_vec(0, -1);
      check_done("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
